// File: rtl/ofm_tx_sched.sv
// ofm_tx_sched: transmit-side frame scheduler for the 10GbE outbound path.
//
// For each frame it pops one 64-bit descriptor from the control FIFO. It then
// streams the matching data words from the data FIFO onto the MAC AXI-Stream
// port, or discards them when the descriptor asks for a drop. Along the way it
// checks the descriptor length against the bytes actually delivered.
//
// Optional feature macro: OFM_TX_IFG_EN
//   defined   -> a GAP state inserts C_IFG_CYCLES idle cycles after every frame
//   undefined -> frame end returns straight to IDLE, C_IFG_CYCLES is ignored
//
// Ports
//   tx_clk, tx_reset          clock, synchronous active-high reset
//   ctrl_fifo_*               FWFT descriptor FIFO read side
//                             [15:0] length in bytes, [16] drop flag
//   data_fifo_*               FWFT data FIFO read side
//                             [63:0] data, [71:64] keep, [72] last
//   tx_axis_*                 AXI-Stream transmit port towards the MAC
//   frame_cnt                 frames sent to the MAC (wraps)
//   drop_cnt, err_cnt         dropped frames / length mismatches (saturate)
//   busy                      state is not IDLE
module ofm_tx_sched #(
    parameter int unsigned C_IFG_CYCLES = 2
) (
    input  logic        tx_clk,
    input  logic        tx_reset,
    input  logic [63:0] ctrl_fifo_rdata,
    input  logic        ctrl_fifo_empty,
    output logic        ctrl_fifo_rden,
    input  logic [72:0] data_fifo_rdata,
    input  logic        data_fifo_empty,
    output logic        data_fifo_rden,
    output logic [63:0] tx_axis_tdata,
    output logic [7:0]  tx_axis_tkeep,
    output logic        tx_axis_tvalid,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    input  logic        tx_axis_tready,
    output logic [31:0] frame_cnt,
    output logic [15:0] drop_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned CNT16  = 16;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;
    localparam logic [CNT16-1:0] CNT_SAT = '1;

`ifdef OFM_TX_IFG_EN
    localparam int unsigned GAP_W = 4;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(C_IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam state_t ST_END = ST_GAP;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam state_t ST_END = ST_IDLE;

    // Parameter has no effect without the inter-frame gap.
    logic [3:0] ifg_unused;
    assign ifg_unused = 4'(C_IFG_CYCLES);
`endif

    // Descriptor bits above the drop flag carry nothing for this block.
    logic [46:0] ctrl_unused;
    assign ctrl_unused = ctrl_fifo_rdata[63:17];

    // Count of set bits in a keep byte.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q, len_d;
    logic             zero_len_q, zero_len_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
`ifdef OFM_TX_IFG_EN
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic [7:0]       d_keep;
    logic             d_last;
    logic [LEN_W:0]   byte_sum;
    logic             in_data;
    logic             in_drop;
    logic             beat_accept;
    logic             frame_inc;
    logic             drop_end;
    logic             err_inc;

    assign d_keep   = data_fifo_rdata[71:64];
    assign d_last   = data_fifo_rdata[72];
    // One bit wider than the counter so an overflowing frame still mismatches.
    assign byte_sum = {1'b0, byte_cnt_q} + (LEN_W+1)'(popcount8(d_keep));

    // Reset gates the handshakes at once so a partial frame is abandoned.
    assign in_data = (state == ST_DATA) && !tx_reset;
    assign in_drop = (state == ST_DROP) && !tx_reset;

    // Zero-latency AXI path: beats come straight from the FWFT head word.
    assign tx_axis_tvalid = in_data && !data_fifo_empty;
    assign tx_axis_tdata  = tx_axis_tvalid ? data_fifo_rdata[63:0] : '0;
    assign tx_axis_tkeep  = tx_axis_tvalid ? d_keep : '0;
    assign tx_axis_tlast  = tx_axis_tvalid && d_last;
    assign tx_axis_tuser  = tx_axis_tvalid && d_last && (byte_sum != {1'b0, len_q});

    assign beat_accept    = tx_axis_tvalid && tx_axis_tready;
    assign data_fifo_rden = beat_accept || (in_drop && !data_fifo_empty);
    assign ctrl_fifo_rden = (state == ST_IDLE) && !ctrl_fifo_empty && !tx_reset;

    assign frame_inc = beat_accept && d_last;
    assign drop_end  = in_drop && !data_fifo_empty && d_last;
    assign err_inc   = (frame_inc && tx_axis_tuser) || (drop_end && zero_len_q);

    assign busy = (state != ST_IDLE);

    // State, descriptor and byte-counter registers.
    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            zero_len_q <= 1'b0;
            byte_cnt_q <= '0;
`ifdef OFM_TX_IFG_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            len_q      <= len_d;
            zero_len_q <= zero_len_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef OFM_TX_IFG_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_nxt  = state;
        len_d      = len_q;
        zero_len_d = zero_len_q;
        byte_cnt_d = byte_cnt_q;
`ifdef OFM_TX_IFG_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        case (state)
            ST_IDLE: begin
                byte_cnt_d = '0;
`ifdef OFM_TX_IFG_EN
                gap_cnt_d  = '0;
`endif
                if (ctrl_fifo_rden) begin
                    len_d      = ctrl_fifo_rdata[15:0];
                    zero_len_d = (ctrl_fifo_rdata[15:0] == '0);
                    if (ctrl_fifo_rdata[16] || (ctrl_fifo_rdata[15:0] == '0)) begin
                        state_nxt = ST_DROP;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (beat_accept) begin
                    byte_cnt_d = byte_sum[LEN_W] ? LEN_SAT : byte_sum[LEN_W-1:0];
                    // Only the last bit ends a frame; the length never truncates.
                    if (d_last) begin
                        state_nxt = ST_END;
                    end
                end
            end
            ST_DROP: begin
                if (drop_end) begin
                    state_nxt = ST_END;
                end
            end
`ifdef OFM_TX_IFG_EN
            ST_GAP: begin
                if (gap_cnt_q >= GAP_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Statistics; saturating counters test the ceiling before incrementing.
    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (drop_end && (drop_cnt != CNT_SAT)) begin
                drop_cnt <= drop_cnt + CNT16'(1);
            end
            if (err_inc && (err_cnt != CNT_SAT)) begin
                err_cnt <= err_cnt + CNT16'(1);
            end
        end
    end

endmodule

// File: tb/tb_ofm_tx_sched.sv
// Testbench for ofm_tx_sched: FWFT FIFO models, randomized stimulus and a
// frame-level reference model (expected beat queue plus expected counters).
module tb_ofm_tx_sched;

    localparam int unsigned IFG = 3;

    logic        tx_clk;
    logic        tx_reset;
    logic [63:0] ctrl_fifo_rdata;
    logic        ctrl_fifo_empty;
    logic        ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata;
    logic        data_fifo_empty;
    logic        data_fifo_rden;
    logic [63:0] tx_axis_tdata;
    logic [7:0]  tx_axis_tkeep;
    logic        tx_axis_tvalid;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    logic        tx_axis_tready;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] err_cnt;
    logic        busy;

    ofm_tx_sched #(.C_IFG_CYCLES(IFG)) dut (
        .tx_clk          (tx_clk),
        .tx_reset        (tx_reset),
        .ctrl_fifo_rdata (ctrl_fifo_rdata),
        .ctrl_fifo_empty (ctrl_fifo_empty),
        .ctrl_fifo_rden  (ctrl_fifo_rden),
        .data_fifo_rdata (data_fifo_rdata),
        .data_fifo_empty (data_fifo_empty),
        .data_fifo_rden  (data_fifo_rden),
        .tx_axis_tdata   (tx_axis_tdata),
        .tx_axis_tkeep   (tx_axis_tkeep),
        .tx_axis_tvalid  (tx_axis_tvalid),
        .tx_axis_tlast   (tx_axis_tlast),
        .tx_axis_tuser   (tx_axis_tuser),
        .tx_axis_tready  (tx_axis_tready),
        .frame_cnt       (frame_cnt),
        .drop_cnt        (drop_cnt),
        .err_cnt         (err_cnt),
        .busy            (busy)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    logic [63:0] cq[$];      // descriptors visible in the control FIFO
    logic [73:0] pend[$];    // data words not yet written ({dropped, word})
    logic [73:0] dq[$];      // data words visible in the data FIFO
    beat_t       exp_q[$];   // beats the MAC must see, in order

    int total = 0;
    int bad   = 0;
    int exp_frames = 0, exp_drops = 0, exp_errs = 0, exp_pops = 0, pops = 0;
    int ready_pct = 100, avail_pct = 100;
    bit ready_toggle = 0;
    bit stall_prev = 0;
    logic [63:0] prev_d;
    logic [8:0]  prev_kl;
    int cyc = 0, first_cyc = 0, prev_last_cyc = 0, span = 0, last_gap = 0, beats = 0;
    bit in_frame = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue one frame: the model decides from the rules what the MAC and counters see.
    task automatic push_frame(input int len, input bit drop, input int nbeats, input int last_bytes);
        logic [63:0] r;
        logic [7:0]  k;
        int          bytes;
        bit          dropped;
        bit          mism;
        beat_t       e;
        r       = {$urandom(), $urandom()};
        dropped = drop || (len == 0);
        bytes   = 8 * (nbeats - 1) + last_bytes;
        mism    = (bytes != len);
        cq.push_back({r[63:17], drop, 16'(len)});
        for (int b = 0; b < nbeats; b++) begin
            k = (b == nbeats - 1) ? (8'hFF >> (8 - last_bytes)) : 8'hFF;
            e.d = {$urandom(), $urandom()};
            e.k = k;
            e.l = (b == nbeats - 1);
            e.u = e.l && mism;
            pend.push_back({dropped, e.l, e.k, e.d});
            if (!dropped) exp_q.push_back(e);
        end
        exp_pops += nbeats;
        if (dropped) begin
            exp_drops++;
            if (len == 0) exp_errs++;
        end else begin
            exp_frames++;
            if (mism) exp_errs++;
        end
    endtask

    // One clock: drive FIFO heads, observe the DUT, retire popped entries.
    task automatic step();
        logic [73:0] w;
        logic [63:0] dummy;
        beat_t       e;
        logic        acc;
        @(negedge tx_clk);
        if (ready_toggle) tx_axis_tready = ~tx_axis_tready;
        else              tx_axis_tready = ($urandom_range(99) < ready_pct);
        for (int i = 0; i < 2; i++)
            if (pend.size() > 0 && $urandom_range(99) < avail_pct) dq.push_back(pend.pop_front());
        ctrl_fifo_empty = (cq.size() == 0);
        ctrl_fifo_rdata = ctrl_fifo_empty ? 64'd0 : cq[0];
        data_fifo_empty = (dq.size() == 0);
        data_fifo_rdata = data_fifo_empty ? 73'd0 : dq[0][72:0];
        #1;
        cyc++;
        acc = tx_axis_tvalid && tx_axis_tready;
        if (stall_prev) begin
            check("hold_valid", 64'(tx_axis_tvalid), 64'd1);
            check("hold_data", tx_axis_tdata, prev_d);
            check("hold_keep_last", 64'({tx_axis_tkeep, tx_axis_tlast}), 64'(prev_kl));
        end
        if (acc) begin
            beats++;
            check("rden_on_accept", 64'(data_fifo_rden), 64'd1);
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("tdata", tx_axis_tdata, e.d);
                check("tkeep", 64'(tx_axis_tkeep), 64'(e.k));
                check("tlast", 64'(tx_axis_tlast), 64'(e.l));
                check("tuser", 64'(tx_axis_tuser), 64'(e.u));
            end
            if (!in_frame) begin
                first_cyc = cyc;
                in_frame  = 1;
            end
            if (tx_axis_tlast) begin
                span          = cyc - first_cyc;
                last_gap      = cyc - prev_last_cyc - 1;
                prev_last_cyc = cyc;
                in_frame      = 0;
            end
        end
        if (data_fifo_rden) begin
            if (dq.size() == 0) begin
                check("rden_empty", 64'd1, 64'd0);
            end else begin
                w = dq.pop_front();
                pops++;
                if (w[73]) check("drop_no_valid", 64'(tx_axis_tvalid), 64'd0);
                else       check("pop_needs_accept", 64'(acc), 64'd1);
            end
        end
        if (ctrl_fifo_rden) begin
            check("ctrl_rden_idle", 64'(busy), 64'd0);
            if (cq.size() == 0) check("ctrl_rden_empty", 64'd1, 64'd0);
            else                dummy = cq.pop_front();
        end
        stall_prev = tx_axis_tvalid && !tx_axis_tready;
        prev_d     = tx_axis_tdata;
        prev_kl    = {tx_axis_tkeep, tx_axis_tlast};
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && pend.size() == 0 && dq.size() == 0 &&
                 cq.size() == 0 && busy == 1'b0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("drain_timeout", 64'd1, 64'd0);
        repeat (2) step();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_frames));
        check({tag, "_drop_cnt"},  64'(drop_cnt),  64'(exp_drops));
        check({tag, "_err_cnt"},   64'(err_cnt),   64'(exp_errs));
        check({tag, "_pops"},      64'(pops),      64'(exp_pops));
    endtask

    initial begin
        int n, nb, lb, bytes, sel, len;
        bit drp;
        logic [63:0] dummy;
        tx_reset        = 1'b1;
        tx_axis_tready  = 1'b0;
        ctrl_fifo_empty = 1'b1;
        ctrl_fifo_rdata = '0;
        data_fifo_empty = 1'b1;
        data_fifo_rdata = '0;
        repeat (3) @(negedge tx_clk);
        #1;
        check("rst_tvalid", 64'(tx_axis_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_counts", {32'(frame_cnt), drop_cnt, err_cnt}, 64'd0);
        tx_reset = 1'b0;

        // Length match: 64 bytes in 8 full beats, back to back.
        push_frame(64, 0, 8, 8);
        drain(200);
        check("match_span", 64'(span), 64'd7);
        check_counters("match");

        // Length mismatch: 64 bytes against 60, then an exact 60-byte frame.
        push_frame(60, 0, 8, 8);
        push_frame(60, 0, 8, 4);
        drain(200);
        check_counters("mismatch");

        // Drop flag, then a normal frame; zero-length descriptor.
        push_frame(24, 1, 3, 8);
        push_frame(16, 0, 2, 8);
        push_frame(0, 0, 2, 5);
        drain(200);
        check_counters("drop");

        // Two queued 1-beat frames: spacing between the two tlast beats.
        push_frame(8, 0, 1, 8);
        push_frame(8, 0, 1, 8);
        drain(200);
`ifdef OFM_TX_IFG_EN
        check("ifg_gap", 64'(last_gap), 64'(IFG + 1));
`else
        check("ifg_gap", 64'(last_gap), 64'd1);
`endif

        // Backpressure: toggling tready, then random tready and FIFO bubbles.
        for (int pass = 0; pass < 2; pass++) begin
            ready_toggle = (pass == 0);
            ready_pct    = 50;
            avail_pct    = 60;
            for (int f = 0; f < 25; f++) begin
                nb    = $urandom_range(6, 1);
                lb    = $urandom_range(8, 1);
                bytes = 8 * (nb - 1) + lb;
                sel   = $urandom_range(9, 0);
                drp   = ($urandom_range(7, 0) == 0);
                if (sel == 0)      len = 0;
                else if (sel == 1) len = bytes + $urandom_range(5, 1);
                else if (sel == 2) len = bytes - 1;
                else               len = bytes;
                push_frame(len, drp, nb, lb);
            end
            drain(3000);
            check_counters(pass == 0 ? "toggle" : "random");
        end

        // Reset mid-frame with both FIFOs still holding data.
        ready_toggle   = 0;
        ready_pct      = 100;
        avail_pct      = 100;
        tx_axis_tready = 1'b1;
        beats          = 0;
        push_frame(64, 0, 8, 8);
        push_frame(16, 0, 2, 8);
        n = 0;
        while (beats < 3 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("reset_setup_timeout", 64'd1, 64'd0);
        @(negedge tx_clk);
        tx_reset = 1'b1;
        @(posedge tx_clk);
        #1;
        check("midrst_tvalid", 64'(tx_axis_tvalid), 64'd0);
        check("midrst_ctrl_rden", 64'(ctrl_fifo_rden), 64'd0);
        check("midrst_data_rden", 64'(data_fifo_rden), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_counts", {32'(frame_cnt), drop_cnt, err_cnt}, 64'd0);
        while (cq.size() > 0)   dummy = cq.pop_front();
        while (dq.size() > 0)   dq.delete(0);
        while (pend.size() > 0) pend.delete(0);
        while (exp_q.size() > 0) exp_q.delete(0);
        exp_frames = 0; exp_drops = 0; exp_errs = 0; exp_pops = 0; pops = 0;
        stall_prev = 0;
        in_frame   = 0;
        @(negedge tx_clk);
        ctrl_fifo_empty = 1'b1;
        data_fifo_empty = 1'b1;
        ctrl_fifo_rdata = '0;
        data_fifo_rdata = '0;
        tx_reset        = 1'b0;

        // Traffic resumes cleanly after reset.
        push_frame(20, 0, 3, 4);
        drain(200);
        check_counters("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
